// File: rtl/fft_pkg.sv
// Shared constants, sample type and index helper for the 8-point FFT datapath.
package fft_pkg;

    localparam int N_POINTS   = 8;
    localparam int LOG2N      = 3;
    localparam int DATA_WIDTH = 13;
    localparam int FRAC_BITS  = 8;

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

    // Q5.8 complex sample as produced by the stage-3 adder/subtractor.
    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] img;
    } cplx_t;

    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/fft_output_reorder_if.sv
// Stream bundle between the last butterfly stage, the reorder buffer and the downstream consumer.
interface fft_output_reorder_if;

    logic signed [fft_pkg::DATA_WIDTH-1:0] IN_Real;
    logic signed [fft_pkg::DATA_WIDTH-1:0] IN_Img;
    logic                                  IN_Valid;
    logic                                  IN_Last;
    logic                                  IN_Ready;
    logic signed [fft_pkg::DATA_WIDTH-1:0] OUT_Real;
    logic signed [fft_pkg::DATA_WIDTH-1:0] OUT_Img;
    logic        [fft_pkg::LOG2N-1:0]      OUT_Index;
    logic                                  OUT_Valid;
    logic                                  OUT_Last;
    logic                                  OUT_Ready;
    logic                                  FRAME_ERR;

    // Surroundings: butterfly producer plus downstream consumer.
    modport master (
        output IN_Real, IN_Img, IN_Valid, IN_Last, OUT_Ready,
        input  IN_Ready, OUT_Real, OUT_Img, OUT_Index, OUT_Valid, OUT_Last, FRAME_ERR
    );

    // The reorder buffer itself.
    modport slave (
        input  IN_Real, IN_Img, IN_Valid, IN_Last, OUT_Ready,
        output IN_Ready, OUT_Real, OUT_Img, OUT_Index, OUT_Valid, OUT_Last, FRAME_ERR
    );

endinterface

// File: rtl/fft_reorder_bank.sv
// One 8-entry complex register bank: synchronous write port, combinational read port.
module fft_reorder_bank
    import fft_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             we,
    input  logic [LOG2N-1:0] waddr,
    input  cplx_t            wdata,
    input  logic [LOG2N-1:0] raddr,
    output cplx_t            rdata
);

    cplx_t mem [N_POINTS];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_POINTS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer: takes bit-reversed FFT results, emits them in natural order.
module fft_output_reorder
    import fft_pkg::*;
(
    input  logic                CLK,
    input  logic                RST_N,
    fft_output_reorder_if.slave bus
);

    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic [LOG2N-1:0] waddr;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic             frame_err_q;
    logic             in_ready;
    logic             accept;
    logic             at_last_slot;
    logic             frame_done;
    logic             frame_bad;
    logic             out_valid;
    logic             rd_fire;
    logic             rd_done;
    logic [1:0]       bank_we;
    cplx_t            wdata;
    cplx_t            rd_sample;
    cplx_t            bank_rdata [2];

    assign in_ready     = !full[wr_bank];
    assign accept       = bus.IN_Valid && in_ready;
    assign at_last_slot = (wr_cnt == LAST_IDX);
    assign frame_done   = accept && at_last_slot && bus.IN_Last;
    // A Last flag and the 8th slot must coincide; anything else drops the partial frame.
    assign frame_bad    = accept && (bus.IN_Last != at_last_slot);

    assign waddr   = bitrev3(wr_cnt);
    assign wdata   = {bus.IN_Real, bus.IN_Img};
    assign bank_we = {accept & wr_bank, accept & ~wr_bank};

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_reorder_bank u_bank (
            .CLK   (CLK),
            .RST_N (RST_N),
            .we    (bank_we[g]),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (rd_cnt),
            .rdata (bank_rdata[g])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_cnt      <= '0;
            wr_bank     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_bad;
            if (accept) begin
                wr_cnt <= frame_bad ? '0 : wr_cnt + 1'b1;
            end
            if (frame_done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    assign out_valid = full[rd_bank];
    assign rd_fire   = out_valid && bus.OUT_Ready;
    assign rd_done   = rd_fire && (rd_cnt == LAST_IDX);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (rd_fire) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_done) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Writer and reader always target different banks when both act, so set and clear never collide.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full <= '0;
        end else begin
            if (frame_done) begin
                full[wr_bank] <= 1'b1;
            end
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    assign rd_sample = bank_rdata[rd_bank];

    assign bus.IN_Ready  = in_ready;
    assign bus.OUT_Valid = out_valid;
    assign bus.OUT_Real  = rd_sample.re;
    assign bus.OUT_Img   = rd_sample.img;
    assign bus.OUT_Index = rd_cnt;
    assign bus.OUT_Last  = out_valid && (rd_cnt == LAST_IDX);
    assign bus.FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Bench for fft_output_reorder: spec vector table, directed corner sequences and a random scoreboard run.
module tb_fft_output_reorder;
    import fft_pkg::*;

    typedef logic signed [DATA_WIDTH-1:0] samp_t;
    typedef struct { samp_t re; samp_t img; logic last; } stim_t;
    typedef struct { samp_t re; samp_t img; logic [LOG2N-1:0] idx; } exp_t;
    typedef struct { samp_t in_re; samp_t in_img; logic in_last; samp_t exp_re; samp_t exp_img; } vec_t;

    logic CLK = 1'b0;
    logic RST_N;

    fft_output_reorder_if bus ();

    fft_output_reorder dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int     vectors_applied = 0;
    int     miscompares     = 0;
    int     model_wr_cnt    = 0;
    int     err_pulses      = 0;
    int     out_count       = 0;
    logic   err_next        = 1'b0;
    stim_t  stim_q [$];
    exp_t   exp_q [$];
    stim_t  arrivals [N_POINTS];
    vec_t   vec_table [N_POINTS];

    function automatic int tb_bitrev(input int k);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (LOG2N - 1 - b));
        end
        return r;
    endfunction

    task automatic check_val(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of the write side: collect arrivals, publish natural-order frame on clean completion.
    task automatic model_accept(input samp_t re, input samp_t img, input logic last);
        logic at_end;
        at_end = (model_wr_cnt == N_POINTS - 1);
        arrivals[model_wr_cnt] = '{re, img, last};
        err_next = (last != at_end);
        if (err_next) begin
            model_wr_cnt = 0;
        end else if (at_end) begin
            for (int n = 0; n < N_POINTS; n++) begin
                exp_q.push_back('{arrivals[tb_bitrev(n)].re, arrivals[tb_bitrev(n)].img, LOG2N'(n)});
            end
            model_wr_cnt = 0;
        end else begin
            model_wr_cnt++;
        end
    endtask

    task automatic check_output();
        check_val("out_real",  32'(bus.OUT_Real),  32'(exp_q[0].re));
        check_val("out_img",   32'(bus.OUT_Img),   32'(exp_q[0].img));
        check_val("out_index", 32'(bus.OUT_Index), 32'(exp_q[0].idx));
        check_val("out_last",  32'(bus.OUT_Last),  32'(exp_q[0].idx == LAST_IDX));
    endtask

    // One clock: check flow-control against the model, observe both handshakes, advance, check FRAME_ERR.
    task automatic step();
        int   full_banks;
        logic fire;
        full_banks = (exp_q.size() + N_POINTS - 1) / N_POINTS;
        check_val("in_ready",  32'(bus.IN_Ready),  32'(full_banks < 2));
        check_val("out_valid", 32'(bus.OUT_Valid), 32'(exp_q.size() > 0));
        if (bus.OUT_Valid && exp_q.size() > 0) check_output();
        fire = bus.OUT_Valid && bus.OUT_Ready && (exp_q.size() > 0);
        err_next = 1'b0;
        if (bus.IN_Valid && bus.IN_Ready) model_accept(bus.IN_Real, bus.IN_Img, bus.IN_Last);
        if (fire) begin
            void'(exp_q.pop_front());
            out_count++;
        end
        @(posedge CLK);
        #1;
        check_val("frame_err", 32'(bus.FRAME_ERR), 32'(err_next));
        if (bus.FRAME_ERR) err_pulses++;
    endtask

    task automatic apply_stimulus(input int valid_pct, input int ready_pct);
        logic acc;
        bus.IN_Valid = (stim_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
        if (stim_q.size() > 0) begin
            bus.IN_Real = stim_q[0].re;
            bus.IN_Img  = stim_q[0].img;
            bus.IN_Last = stim_q[0].last;
        end else begin
            bus.IN_Real = '0;
            bus.IN_Img  = '0;
            bus.IN_Last = 1'b0;
        end
        bus.OUT_Ready = ($urandom_range(0, 99) < ready_pct);
        acc = bus.IN_Valid && bus.IN_Ready;
        step();
        if (acc) void'(stim_q.pop_front());
    endtask

    task automatic push_sample(input samp_t re, input samp_t img, input logic last);
        stim_q.push_back('{re, img, last});
    endtask

    task automatic drain(input string name, input int bound);
        for (int c = 0; c < bound && (stim_q.size() > 0 || exp_q.size() > 0); c++) begin
            apply_stimulus(100, 100);
        end
        check_val({name, "_drained"}, 32'(stim_q.size() + exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, "_in_ready"},  32'(bus.IN_Ready),  1);
        check_val({name, "_out_valid"}, 32'(bus.OUT_Valid), 0);
        check_val({name, "_out_real"},  32'(bus.OUT_Real),  0);
        check_val({name, "_out_img"},   32'(bus.OUT_Img),   0);
        check_val({name, "_out_index"}, 32'(bus.OUT_Index), 0);
        check_val({name, "_out_last"},  32'(bus.OUT_Last),  0);
        check_val({name, "_frame_err"}, 32'(bus.FRAME_ERR), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_out;
        int start_err;
        int drops;
        int bubbles;

        vec_table[0] = '{13'sd0,   13'sd0,  1'b0, 13'sd0,    13'sd0};
        vec_table[1] = '{13'sd16, -13'sd1,  1'b0, 13'sd64,  -13'sd4};
        vec_table[2] = '{13'sd32, -13'sd2,  1'b0, 13'sd32,  -13'sd2};
        vec_table[3] = '{13'sd48, -13'sd3,  1'b0, 13'sd96,  -13'sd6};
        vec_table[4] = '{13'sd64, -13'sd4,  1'b0, 13'sd16,  -13'sd1};
        vec_table[5] = '{13'sd80, -13'sd5,  1'b0, 13'sd80,  -13'sd5};
        vec_table[6] = '{13'sd96, -13'sd6,  1'b0, 13'sd48,  -13'sd3};
        vec_table[7] = '{13'sd112,-13'sd7,  1'b1, 13'sd112, -13'sd7};

        RST_N         = 1'b0;
        bus.IN_Real   = '0;
        bus.IN_Img    = '0;
        bus.IN_Valid  = 1'b0;
        bus.IN_Last   = 1'b0;
        bus.OUT_Ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("por");
        RST_N = 1'b1;

        $display("[TB] single frame from vector table");
        for (int k = 0; k < N_POINTS; k++) begin
            bus.IN_Valid  = 1'b1;
            bus.IN_Real   = vec_table[k].in_re;
            bus.IN_Img    = vec_table[k].in_img;
            bus.IN_Last   = vec_table[k].in_last;
            bus.OUT_Ready = 1'b1;
            step();
        end
        bus.IN_Valid = 1'b0;
        bus.IN_Last  = 1'b0;
        check_val("latency_x0_valid", 32'(bus.OUT_Valid), 1);
        for (int n = 0; n < N_POINTS; n++) begin
            check_val("tbl_real",  32'(bus.OUT_Real),  32'(vec_table[n].exp_re));
            check_val("tbl_img",   32'(bus.OUT_Img),   32'(vec_table[n].exp_img));
            check_val("tbl_index", 32'(bus.OUT_Index), n);
            check_val("tbl_last",  32'(bus.OUT_Last),  32'(n == N_POINTS - 1));
            step();
        end
        check_val("tbl_empty_after", 32'(bus.OUT_Valid), 0);

        $display("[TB] backpressure with three frames offered");
        start_out = out_count;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N_POINTS; k++) begin
                push_sample(13'(f * 200 + k * 7 + 1), 13'(-(f * 30 + k * 3) - 1), k == N_POINTS - 1);
            end
        end
        for (int c = 0; c < 30; c++) apply_stimulus(100, 0);
        check_val("bp_accepted", 32'(24 - stim_q.size()), 16);
        check_val("bp_in_ready", 32'(bus.IN_Ready), 0);
        check_val("bp_hold_index", 32'(bus.OUT_Index), 0);
        check_val("bp_hold_real", 32'(bus.OUT_Real), 32'(samp_t'(13'sd1)));
        drain("bp", 100);
        check_val("bp_out_count", out_count - start_out, 24);

        $display("[TB] streaming four frames");
        start_out = out_count;
        drops     = 0;
        bubbles   = 0;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < N_POINTS; k++) begin
                push_sample(13'(f * 64 + k * 5 - 100), 13'(-(f * 8 + k)), k == N_POINTS - 1);
            end
        end
        for (int c = 0; c < 100 && (stim_q.size() > 0 || exp_q.size() > 0); c++) begin
            if (stim_q.size() > 0 && !bus.IN_Ready) drops++;
            if (out_count > start_out && out_count - start_out < 32 && !bus.OUT_Valid) bubbles++;
            apply_stimulus(100, 100);
        end
        check_val("stream_in_ready_drops", drops, 0);
        check_val("stream_out_bubbles", bubbles, 0);
        check_val("stream_out_count", out_count - start_out, 32);

        $display("[TB] framing error: early last");
        start_out = out_count;
        start_err = err_pulses;
        for (int k = 0; k < 5; k++) push_sample(13'(300 + k), 13'(k), k == 4);
        for (int k = 0; k < N_POINTS; k++) push_sample(13'(-500 + k * 11), 13'(40 - k), k == N_POINTS - 1);
        drain("early", 100);
        check_val("early_err_pulses", err_pulses - start_err, 1);
        check_val("early_out_count", out_count - start_out, 8);

        $display("[TB] framing error: missing last");
        start_out = out_count;
        start_err = err_pulses;
        for (int k = 0; k < N_POINTS; k++) push_sample(13'(700 + k), 13'(-700 - k), 1'b0);
        for (int k = 0; k < N_POINTS; k++) push_sample(13'(k * 13), 13'(-k * 17), k == N_POINTS - 1);
        drain("missing", 100);
        check_val("missing_err_pulses", err_pulses - start_err, 1);
        check_val("missing_out_count", out_count - start_out, 8);

        $display("[TB] reset mid-frame");
        for (int k = 0; k < N_POINTS; k++) push_sample(13'(900 + k), 13'(-900 + k), k == N_POINTS - 1);
        for (int k = 0; k < 4; k++) push_sample(13'(1000 + k), 13'(k), 1'b0);
        for (int c = 0; c < 12; c++) apply_stimulus(100, 0);
        for (int c = 0; c < 2; c++) apply_stimulus(100, 100);
        bus.OUT_Ready = 1'b0;
        bus.IN_Valid  = 1'b0;
        #3;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("midrst");
        stim_q.delete();
        exp_q.delete();
        model_wr_cnt = 0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        start_out = out_count;
        for (int k = 0; k < N_POINTS; k++) push_sample(13'(-k * 31), 13'(k * 29), k == N_POINTS - 1);
        drain("postrst", 100);
        check_val("postrst_out_count", out_count - start_out, 8);

        $display("[TB] random traffic, 100 frames");
        start_out = out_count;
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < N_POINTS; k++) begin
                push_sample(samp_t'($urandom_range(0, 8191)), samp_t'($urandom_range(0, 8191)), k == N_POINTS - 1);
            end
        end
        for (int c = 0; c < 6000 && stim_q.size() > 0; c++) apply_stimulus(70, 60);
        drain("random", 200);
        check_val("random_out_count", out_count - start_out, 800);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
